median_seq: RTL and testbench

- Parametrised sequential median engine: accepts NB samples of WIDTH bits over a valid-strobe input and returns their median after an iterative compare-exchange sort.
- Uses a single compare-exchange unit, time-multiplexed over a register ring.
- Generalises the fixed 9-pixel, 8-bit median datapath to any odd window size and any sample width.
- Adds explicit ready and output-valid signalling.

---
 rtl/median_pkg.sv | 26 ++
 rtl/MCE.sv | 22 ++
 rtl/median_seq.sv | 133 +++++++++++++
 tb/tb_median_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the sequential median engine: FSM encoding and
// helpers that size the window, step and pass counters from NB.
package median_pkg;

    typedef logic [1:0] state_t;

    localparam state_t LOAD    = 2'd0;
    localparam state_t COMPUTE = 2'd1;
    localparam state_t OUT     = 2'd2;

    // Number of max-removal passes needed to expose the median.
    function automatic int npass(input int nb);
        return (nb + 1) / 2;
    endfunction

    // Steps per pass: one per entry of the (NB-1)-deep ring.
    function automatic int nstep(input int nb);
        return nb - 1;
    endfunction

    // Bits needed for a counter spanning 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/MCE.sv
// Compare-exchange cell: routes the larger of a/b to max and the smaller
// to min, unsigned.
module MCE #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] max,
    output logic [SIZE-1:0] min
);

    always_comb begin
        if (a > b) begin
            max = a;
            min = b;
        end else begin
            max = b;
            min = a;
        end
    end

endmodule

// File: rtl/median_seq.sv
// Sequential median of NB samples: one compare-exchange cell sweeps a ring
// of NB-1 registers, peeling off the running maximum once per pass.
module median_seq
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NB    = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DSI,
    input  logic [WIDTH-1:0] DI,
    output logic             RDY,
    output logic             DSO,
    output logic [WIDTH-1:0] DO
);

    localparam int NPASS = npass(NB);
    localparam int NSTEP = nstep(NB);
    localparam int SW    = cnt_w(NB);
    localparam int TW    = cnt_w(NSTEP);
    localparam int PW    = cnt_w(NPASS);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(NB - 1);
    localparam logic [TW-1:0] STEP_LAST   = TW'(NSTEP - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(NPASS - 1);

    if (NB < 3 || (NB % 2) == 0) begin : g_nb_check
        $error("median_seq: NB must be odd and >= 3");
    end
    if (WIDTH < 1) begin : g_width_check
        $error("median_seq: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] r_q [NB];
    logic [WIDTH-1:0] r_d [NB];
    state_t           state_q, state_d;
    logic [SW-1:0]    sample_q, sample_d;
    logic [TW-1:0]    step_q, step_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] mce_max, mce_min;

    MCE #(.SIZE(WIDTH)) u_mce (
        .a   (r_q[NB-1]),
        .b   (r_q[NB-2]),
        .max (mce_max),
        .min (mce_min)
    );

    always_comb begin
        r_d      = r_q;
        state_d  = state_q;
        sample_d = sample_q;
        step_d   = step_q;
        pass_d   = pass_q;
        start_d  = start_q;
        case (state_q)
            LOAD: begin
                if (DSI) begin
                    r_d[0] = DI;
                    for (int i = 1; i < NB; i++) begin
                        r_d[i] = r_q[i-1];
                    end
                    if (sample_q == SAMPLE_LAST) begin
                        sample_d = '0;
                        step_d   = '0;
                        pass_d   = '0;
                        start_d  = 1'b1;
                        state_d  = COMPUTE;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // The first COMPUTE cycle only lets the freshly loaded window settle.
                if (start_q) begin
                    start_d = 1'b0;
                end else begin
                    r_d[0]    = mce_min;
                    for (int i = 1; i < NB - 1; i++) begin
                        r_d[i] = r_q[i-1];
                    end
                    r_d[NB-1] = mce_max;
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (pass_q == PASS_LAST) begin
                            state_d = OUT;
                        end else begin
                            // Zero never outranks a real sample, so it cleanly discards the max.
                            r_d[NB-1] = '0;
                            pass_d    = pass_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            OUT: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NB; i++) begin
                r_q[i] <= '0;
            end
            state_q  <= LOAD;
            sample_q <= '0;
            step_q   <= '0;
            pass_q   <= '0;
            start_q  <= 1'b0;
        end else begin
            r_q      <= r_d;
            state_q  <= state_d;
            sample_q <= sample_d;
            step_q   <= step_d;
            pass_q   <= pass_d;
            start_q  <= start_d;
        end
    end

    assign RDY = (state_q == LOAD);
    assign DSO = (state_q == OUT);
    assign DO  = r_q[NB-1];

endmodule

// File: tb/tb_median_seq.sv
// Directed and random checks of median_seq at NB=9/5/3 using a scoreboard
// of expected medians and DSO cycle numbers.
module tb_median_seq;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dsi9, dsi5, dsi3;
    logic [7:0] di9, di5;
    logic [3:0] di3;
    logic       rdy9, rdy5, rdy3;
    logic       dso9, dso5, dso3;
    logic [7:0] do9, do5;
    logic [3:0] do3;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc;
    exp_t q9[$], q5[$], q3[$];
    exp_t e9, e5, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_seq #(.WIDTH(8), .NB(9)) dut9 (
        .CLK(clk), .RST(rst), .DSI(dsi9), .DI(di9), .RDY(rdy9), .DSO(dso9), .DO(do9)
    );
    median_seq #(.WIDTH(8), .NB(5)) dut5 (
        .CLK(clk), .RST(rst), .DSI(dsi5), .DI(di5), .RDY(rdy5), .DSO(dso5), .DO(do5)
    );
    median_seq #(.WIDTH(4), .NB(3)) dut3 (
        .CLK(clk), .RST(rst), .DSI(dsi3), .DI(di3), .RDY(rdy3), .DSO(dso3), .DO(do3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int median_of(input int s[$]);
        int t[$];
        int tmp;
        t = s;
        for (int i = 1; i < t.size(); i++) begin
            for (int j = i; j > 0 && t[j-1] > t[j]; j--) begin
                tmp = t[j]; t[j] = t[j-1]; t[j-1] = tmp;
            end
        end
        return t[t.size() / 2];
    endfunction

    // Waits (bounded) for RDY on the chosen instance, then presents one sample.
    task automatic send(input int which, input int v);
        int   n = 0;
        logic r;
        @(negedge clk);
        r = (which == 9) ? rdy9 : (which == 5) ? rdy5 : rdy3;
        while (r !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            r = (which == 9) ? rdy9 : (which == 5) ? rdy5 : rdy3;
        end
        chk("send_rdy", r, 1);
        case (which)
            9:       begin dsi9 = 1'b1; di9 = 8'(v); end
            5:       begin dsi5 = 1'b1; di5 = 8'(v); end
            default: begin dsi3 = 1'b1; di3 = 4'(v); end
        endcase
        @(posedge clk);
        #1;
        dsi9 = 1'b0; dsi5 = 1'b0; dsi3 = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic win(input int which, input int s[$], input int gap, input int expv);
        exp_t e;
        for (int i = 0; i < s.size(); i++) begin
            send(which, s[i]);
            if (i != s.size() - 1) repeat (gap) @(negedge clk);
        end
        e.val = expv;
        e.cyc = acc_cyc + ((which + 1) / 2) * (which - 1) + 1;
        case (which)
            9:       q9.push_back(e);
            5:       q5.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic drain();
        int n = 0;
        while ((q9.size() + q5.size() + q3.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q9.size() + q5.size() + q3.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (dso9 === 1'b1) begin
            chk("dso9_expected", q9.size() > 0, 1);
            if (q9.size() > 0) begin
                e9 = q9.pop_front();
                chk("do9", do9, e9.val);
                chk("lat9", cyc, e9.cyc);
            end
            chk("rdy9_in_dso", rdy9, 0);
            @(negedge clk);
            chk("rdy9_after_dso", rdy9, 1);
            chk("dso9_one_cycle", dso9, 0);
        end
    end

    always @(negedge clk) begin
        if (dso5 === 1'b1) begin
            chk("dso5_expected", q5.size() > 0, 1);
            if (q5.size() > 0) begin
                e5 = q5.pop_front();
                chk("do5", do5, e5.val);
                chk("lat5", cyc, e5.cyc);
            end
            chk("rdy5_in_dso", rdy5, 0);
            @(negedge clk);
            chk("dso5_one_cycle", dso5, 0);
        end
    end

    always @(negedge clk) begin
        if (dso3 === 1'b1) begin
            chk("dso3_expected", q3.size() > 0, 1);
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                chk("do3", do3, e3.val);
                chk("lat3", cyc, e3.cyc);
            end
            chk("rdy3_in_dso", rdy3, 0);
            @(negedge clk);
            chk("dso3_one_cycle", dso3, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s[$];
        dsi9 = 1'b0; dsi5 = 1'b0; dsi3 = 1'b0;
        di9 = '0; di5 = '0; di3 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        chk("reset_rdy9", rdy9, 1);
        chk("reset_dso9", dso9, 0);
        chk("reset_do9", do9, 0);
        chk("reset_rdy5", rdy5, 1);
        chk("reset_rdy3", rdy3, 1);
        chk("reset_do3", do3, 0);
        repeat (100) begin
            @(negedge clk);
            chk("idle_dso", {dso9, dso5, dso3}, 0);
        end

        s = '{7, 2, 8, 0, 5, 3, 6, 1, 4};
        win(9, s, 0, 4);
        @(negedge clk);
        chk("rdy9_compute", rdy9, 0);

        s = '{0, 0, 0, 0, 9, 9, 9, 9, 9};
        win(9, s, 0, 9);
        s = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
        win(9, s, 0, 0);

        s = '{7, 2, 8, 0, 5, 3, 6, 1, 4};
        win(9, s, 3, 4);
        @(negedge clk);
        dsi9 = 1'b1;
        di9  = 8'd200;
        repeat (4) @(negedge clk);
        chk("rdy9_compute_gap", rdy9, 0);
        dsi9 = 1'b0;
        drain();

        for (int i = 1; i <= 9; i++) send(9, i);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rdy9", rdy9, 1);
        chk("async_rst_do9", do9, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        s = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        win(9, s, 0, 50);

        s = '{15, 0, 7};
        win(3, s, 0, 7);
        drain();

        for (int w = 0; w < 100; w++) begin
            s.delete();
            for (int k = 0; k < 5; k++) s.push_back(int'($urandom_range(0, 255)));
            win(5, s, 0, median_of(s));
        end
        for (int w = 0; w < 100; w++) begin
            s.delete();
            for (int k = 0; k < 9; k++) s.push_back(int'($urandom_range(0, 255)));
            win(9, s, 0, median_of(s));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
